// File: rtl/wb_stage.sv
// Write-back stage: load extraction/extension, one registered commit slot, trace and hazard view.
// Optional WB_RETIRE_CNT_EN adds a 64-bit count of retired instructions.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic [31:0] PC,
    input  logic [7:0]  load_op,
    input  logic        res_from_mem,
    input  logic        gr_we,
    input  logic [4:0]  dest,
    input  logic [31:0] data_sram_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    // Picks the addressed byte/half from the SRAM word and extends it per load type.
    function automatic logic [31:0] load_extend(
        input logic [7:0]  op,
        input logic [31:0] rdata,
        input logic [1:0]  off
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        logic signed [31:0] ws;
        logic        [31:0] ld;
        b  = rdata[8*off +: 8];
        h  = off[1] ? rdata[31:16] : rdata[15:0];
        bs = b;
        hs = h;
        ld = rdata;
        if (op[0]) begin
            ws = bs;
            ld = ws;
        end else if (op[1]) begin
            ld = {24'd0, b};
        end else if (op[2]) begin
            ws = hs;
            ld = ws;
        end else if (op[3]) begin
            ld = {16'd0, h};
        end else if (op[4] || (op[7:5] != 3'b000)) begin
            ld = rdata;
        end
        return ld;
    endfunction

    logic        vld_p1;
    logic        we_p1;
    logic [4:0]  dest_p1;
    logic [31:0] pc_p1;
    logic [31:0] wdata_p1;
    logic [31:0] wdata_p0;
    logic        accept_p0;

    assign in_ready  = ~rst & (~vld_p1 | 1'b1);
    assign accept_p0 = in_valid & in_ready;
    assign wdata_p0  = res_from_mem ? load_extend(load_op, data_sram_rdata, result[1:0])
                                    : result;

    // p0 -> p1: capture the instruction together with its SRAM word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            dest_p1  <= 5'd0;
            pc_p1    <= RESET_PC;
            wdata_p1 <= 32'd0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                we_p1    <= gr_we & (dest != 5'd0);
                dest_p1  <= dest;
                pc_p1    <= PC;
                wdata_p1 <= wdata_p0;
            end
        end
    end

    assign wb_valid          = vld_p1;
    assign rf_we             = vld_p1 & we_p1;
    assign rf_waddr          = dest_p1;
    assign rf_wdata          = wdata_p1;
    assign wb_dest           = rf_we ? dest_p1 : 5'd0;
    assign debug_wb_pc       = pc_p1;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= 64'd0;
        end else if (vld_p1) begin
            cnt_p1 <= cnt_p1 + 64'd1;
        end
    end

    assign retire_cnt = cnt_p1;
`endif

endmodule
